// File: rtl/sc_gate_pkg.sv
// Shared constants for the gate bank: operation-select width and mode encodings.
package sc_gate_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_NOT  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_BUF  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_AND  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_OR   = 3'd3;
  localparam logic [MODE_W-1:0] MODE_XOR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_NAND = 3'd5;
  localparam logic [MODE_W-1:0] MODE_NOR  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_XNOR = 3'd7;

endpackage

// File: rtl/sc_gate_bank_stage.sv
// One elastic pipeline slot: WIDTH-bit data register plus valid bit, loaded when i_en is high.
module sc_gate_bank_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/sc_gate_bank.sv
// Bitwise eight-operation gate bank feeding a STAGES-deep valid/ready pipeline with a transfer counter.
module sc_gate_bank
  import sc_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              SC_GateBank_CLOCK_50,
  input  logic              SC_GateBank_RESET_InHigh,
  input  logic [WIDTH-1:0]  SC_GateBank_a_In,
  input  logic [WIDTH-1:0]  SC_GateBank_b_In,
  input  logic [MODE_W-1:0] SC_GateBank_mode_In,
  input  logic              SC_GateBank_valid_In,
  output logic              SC_GateBank_ready_Out,
  output logic [WIDTH-1:0]  SC_GateBank_z_Out,
  output logic              SC_GateBank_valid_Out,
  input  logic              SC_GateBank_ready_In,
  output logic [CNT_W-1:0]  SC_GateBank_count_Out
);

  logic [WIDTH-1:0] w_op;
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_load;
  logic [WIDTH-1:0] w_data [STAGES];
  logic w_hole;
  logic w_out_hs;
  logic [CNT_W-1:0] r_count;

  always_comb begin
    w_op = '0;
    case (SC_GateBank_mode_In)
      MODE_NOT:  w_op = ~SC_GateBank_a_In;
      MODE_BUF:  w_op = SC_GateBank_a_In;
      MODE_AND:  w_op = SC_GateBank_a_In & SC_GateBank_b_In;
      MODE_OR:   w_op = SC_GateBank_a_In | SC_GateBank_b_In;
      MODE_XOR:  w_op = SC_GateBank_a_In ^ SC_GateBank_b_In;
      MODE_NAND: w_op = ~(SC_GateBank_a_In & SC_GateBank_b_In);
      MODE_NOR:  w_op = ~(SC_GateBank_a_In | SC_GateBank_b_In);
      MODE_XNOR: w_op = ~(SC_GateBank_a_In ^ SC_GateBank_b_In);
      default:   w_op = '0;
    endcase
  end

  // A stage may load if it, or any stage downstream of it, is empty, or the output drains.
  // This is the closed form of "empty or moving on" and avoids a combinational loop.
  always_comb begin
    w_hole = 1'b0;
    w_load = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      w_hole    = w_hole | ~w_valid[i];
      w_load[i] = SC_GateBank_ready_In | w_hole;
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      sc_gate_bank_stage #(.WIDTH(WIDTH)) u_stage (
        .i_clk   (SC_GateBank_CLOCK_50),
        .i_rst   (SC_GateBank_RESET_InHigh),
        .i_en    (w_load[gi]),
        .i_valid (SC_GateBank_valid_In),
        .i_data  (w_op),
        .o_valid (w_valid[gi]),
        .o_data  (w_data[gi])
      );
    end else begin : g_rest
      sc_gate_bank_stage #(.WIDTH(WIDTH)) u_stage (
        .i_clk   (SC_GateBank_CLOCK_50),
        .i_rst   (SC_GateBank_RESET_InHigh),
        .i_en    (w_load[gi]),
        .i_valid (w_valid[gi-1]),
        .i_data  (w_data[gi-1]),
        .o_valid (w_valid[gi]),
        .o_data  (w_data[gi])
      );
    end
  end

  assign w_out_hs = w_valid[STAGES-1] & SC_GateBank_ready_In;

  always_ff @(posedge SC_GateBank_CLOCK_50 or posedge SC_GateBank_RESET_InHigh) begin
    if (SC_GateBank_RESET_InHigh) begin
      r_count <= '0;
    end else if (w_out_hs) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign SC_GateBank_ready_Out = w_load[0];
  assign SC_GateBank_z_Out     = w_data[STAGES-1];
  assign SC_GateBank_valid_Out = w_valid[STAGES-1];
  assign SC_GateBank_count_Out = r_count;

endmodule

// File: doc/sc_gate_bank.md
Name: sc_gate_bank

Overview:
- Parametrised, pipelined successor to the single-bit inverter gate.
- Applies one of eight bitwise logic operations to two WIDTH-bit operands, selected per transaction.
- Results pass through a STAGES-deep elastic pipeline with valid/ready flow control and a running output-transaction count.
- Sits between operand sources (switch/register blocks) and downstream consumers (display or register stages) in the lab datapath.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
STAGES, 2, number of pipeline register stages (>=1)
CNT_W, 8, width of the completed-transaction counter

Ports:
SC_GateBank_CLOCK_50  input  1  system clock, rising edge
SC_GateBank_RESET_InHigh  input  1  asynchronous reset, active-high
SC_GateBank_a_In  input  WIDTH  operand A
SC_GateBank_b_In  input  WIDTH  operand B (ignored by NOT/BUF)
SC_GateBank_mode_In  input  3  operation select
SC_GateBank_valid_In  input  1  upstream operands valid
SC_GateBank_ready_Out  output  1  block can accept operands this cycle
SC_GateBank_z_Out  output  WIDTH  result
SC_GateBank_valid_Out  output  1  z_Out valid
SC_GateBank_ready_In  input  1  downstream accepts result
SC_GateBank_count_Out  output  CNT_W  completed output transfers, modulo 2^CNT_W

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, sync release):
  - All stage valid bits = 0; all stage data = 0.
  - z_Out = 0, valid_Out = 0, count_Out = 0.
  - ready_Out = 1 as soon as reset is deasserted.
- Mode encoding (applied bitwise across WIDTH):
  - 0 NOT a, 1 BUF a, 2 AND, 3 OR, 4 XOR, 5 NAND, 6 NOR, 7 XNOR.
- Operation timing:
  - Computed combinationally from a_In/b_In/mode_In.
  - Captured into stage 0 on input handshake (valid_In & ready_Out).
  - Later stages carry the result only; mode is not carried.
- Stage advance rule:
  - Stage i loads from stage i-1 (or from the input for i=0) when stage i is empty, or when stage i's contents move on this cycle.
  - The last stage moves on when valid_Out & ready_In.
- Ready path:
  - ready_Out = !valid[0] | advance[0].
  - ready_Out depends combinationally on ready_In through the chain; no registered skid.
- Latency and throughput:
  - Latency = STAGES cycles from input handshake to valid_Out with no stall.
  - Throughput = 1 transfer/cycle when ready_In is held high.
- Output registers:
  - z_Out and valid_Out come directly from the last stage's registers.
  - While valid_Out=1 & ready_In=0, z_Out holds stable.
- Full pipeline: with all STAGES valid and ready_In=0, ready_Out=0 and no input is accepted.
- Simultaneous events: with the pipeline full and ready_In=1, the output handshake and input handshake occur in the same cycle with no bubble.
- Ordering: strict FIFO; no drop or duplication under any valid/ready pattern.
- Counter:
  - count_Out increments by 1 on each output handshake.
  - Wraps from 2^CNT_W-1 to 0.
  - Not affected by input handshakes.
- Reset mid-operation: in-flight items are discarded; valid_Out falls immediately on reset assertion; nothing from before reset is emitted afterwards.
- Input holding: an input that is not accepted (ready_Out=0) is not sampled; upstream must hold it.

Decomposition:
- Shared package sc_gate_pkg:
  - Mode constants MODE_NOT..MODE_XNOR (3-bit localparams).
  - Mode width constant (3).
- One natural sub-module: sc_gate_bank_stage, a single WIDTH-bit register plus valid bit with load enable and async reset.
  - Instantiated STAGES times via generate.
  - Op decoder and counter stay in the top module.

Test Plan (WIDTH=8, STAGES=2, CNT_W=8 unless noted):
- Reset: assert RESET_InHigh mid-clock -> z_Out=8'h00, valid_Out=0, count_Out=0 immediately; after release ready_Out=1.
- NOT: a=8'hA5, mode=0, one-cycle valid_In, ready_In=1 -> valid_Out high exactly 2 cycles after accept, z_Out=8'h5A for one cycle, count_Out=1.
- Mode sweep: a=8'hF0, b=8'hCC, modes 0..7 back-to-back, ready_In=1 -> z_Out sequence 0F,F0,C0,FC,3C,3F,03,C3 on consecutive cycles, count_Out=8.
- Backpressure: ready_In=0 and three operands offered -> exactly 2 accepted, ready_Out=0, z_Out stable. Release ready_In -> results emerge in order, third operand then accepted, no loss or duplication.
- Reset mid-operation: 2 items in flight, pulse reset -> valid_Out=0 at once; no output after release until new input; count_Out=0.
- Counter wrap (CNT_W=4): 17 output transfers -> count_Out=1.
